// File: rtl/pport_nibble_rx.sv
// pport_nibble_rx: parallel-port byte receiver that splits each byte into a low/high nibble pair and queues them.
// Revision 1.0 - initial release
`default_nettype none

module pport_nibble_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int STB_FILTER = 4,
  parameter int ACK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pp_data,
  input  logic       pp_strobe_n,
  input  logic       remote_ack,
  input  logic       overrun_clr,
  output logic       pp_ack_n,
  output logic       pp_busy,
  output logic [3:0] remote_d,
  output logic       remote_data_ready,
  output logic       overrun
);

  localparam int           AW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0]   FILT_N  = 4'(STB_FILTER);
  localparam logic [7:0]   ACK_N   = 8'(ACK_CYCLES);
  localparam logic [AW:0]  OCC_MAX = (AW+1)'(FIFO_DEPTH - 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILTER    = 3'd1,
    PUSH      = 3'd2,
    ACK       = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          stb_meta_q, stb_q;
  logic [7:0]    data_meta_q, data_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    ackcnt_q, ackcnt_d;
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [3:0]    rd_q, head_d;
  logic          rdy_q, ovr_q;

  logic          push, drop, pop, room, empty;
  logic [AW:0]   occ;
  logic [AW-1:0] widx0, widx1, hidx;

  assign occ   = wptr_q - rptr_q;
  assign room  = (occ <= OCC_MAX);
  assign empty = (wptr_q == rptr_q);
  assign widx0 = wptr_q[AW-1:0];
  assign widx1 = widx0 + AW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ackcnt_d = ackcnt_q;
    push     = 1'b0;
    drop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stb_q) begin
          state_d = FILTER;
          cnt_d   = 4'd1;
        end
      end
      FILTER: begin
        if (stb_q)               state_d = IDLE;
        else if (cnt_q == FILT_N) state_d = PUSH;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      PUSH: begin
        // Free-space test uses pre-pop occupancy, so a same-cycle pop never rescues a byte.
        push     = room;
        drop     = !room;
        ackcnt_d = ACK_N;
        state_d  = ACK;
      end
      ACK: begin
        ackcnt_d = ackcnt_q - 8'd1;
        if (ackcnt_q == 8'd1) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (stb_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pop    = remote_ack && !empty;
    wptr_d = push ? wptr_q + (AW+1)'(2) : wptr_q;
    rptr_d = rptr_q + (AW+1)'(pop);

    // Head may be a slot being written this same cycle.
    hidx   = rptr_d[AW-1:0];
    head_d = mem_q[hidx];
    if (push && hidx == widx0)      head_d = data_q[3:0];
    else if (push && hidx == widx1) head_d = data_q[7:4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stb_meta_q  <= 1'b1;
      stb_q       <= 1'b1;
      data_meta_q <= 8'h00;
      data_q      <= 8'h00;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ackcnt_q    <= 8'd0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rd_q        <= 4'h0;
      rdy_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      stb_meta_q  <= pp_strobe_n;
      stb_q       <= stb_meta_q;
      data_meta_q <= pp_data;
      data_q      <= data_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ackcnt_q    <= ackcnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rd_q        <= head_d;
      rdy_q       <= (wptr_d != rptr_d);
      if (drop)             ovr_q <= 1'b1;
      else if (overrun_clr) ovr_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[widx0] <= data_q[3:0];
      mem_q[widx1] <= data_q[7:4];
    end
  end

  assign pp_ack_n          = (state_q != ACK);
  assign pp_busy           = (state_q != IDLE) || !room;
  assign remote_d          = rd_q;
  assign remote_data_ready = rdy_q;
  assign overrun           = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_pport_nibble_rx.sv
// tb_pport_nibble_rx: scoreboard bench for pport_nibble_rx with default parameters.
// Revision 1.0 - initial release
`default_nettype none

module tb_pport_nibble_rx;

  localparam int DEPTH = 8;
  localparam int ACKW  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pp_data;
  logic       pp_strobe_n;
  logic       remote_ack;
  logic       overrun_clr;
  logic       pp_ack_n;
  logic       pp_busy;
  logic [3:0] remote_d;
  logic       remote_data_ready;
  logic       overrun;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] sb_q[$];
  logic       exp_ovr = 1'b0;

  pport_nibble_rx dut (
    .clk               (clk),
    .reset             (reset),
    .pp_data           (pp_data),
    .pp_strobe_n       (pp_strobe_n),
    .remote_ack        (remote_ack),
    .overrun_clr       (overrun_clr),
    .pp_ack_n          (pp_ack_n),
    .pp_busy           (pp_busy),
    .remote_d          (remote_d),
    .remote_data_ready (remote_data_ready),
    .overrun           (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Queue the expected nibbles (or predict a drop) before driving a byte.
  task automatic model_byte(input logic [7:0] b);
    if (DEPTH - sb_q.size() >= 2) begin
      sb_q.push_back(b[3:0]);
      sb_q.push_back(b[7:4]);
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int low_cycles);
    int t = 0, width = 0, falls = 0;
    logic prev = 1'b1;
    model_byte(b);
    pp_data     = b;
    pp_strobe_n = 1'b0;
    while (t < 400) begin
      @(negedge clk);
      t++;
      if (t == low_cycles) pp_strobe_n = 1'b1;
      if (!pp_ack_n) width++;
      if (prev && !pp_ack_n) falls++;
      prev = pp_ack_n;
      if (falls > 0 && pp_ack_n && pp_strobe_n) break;
    end
    repeat (4) @(negedge clk);
    check("ack_width", width, ACKW);
    check("ack_falls", falls, 1);
    check("overrun", int'(overrun), int'(exp_ovr));
  endtask

  task automatic pop_one(input string tag);
    logic [3:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_rdy"}, int'(remote_data_ready), 1);
      check({tag, "_d"}, int'(remote_d), int'(e));
    end
    remote_ack = 1'b1;
    @(negedge clk);
    remote_ack = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (sb_q.size() > 0) pop_one(tag);
    @(negedge clk);
    check({tag, "_empty_rdy"}, int'(remote_data_ready), 0);
  endtask

  initial begin
    int   t;
    logic ack_seen;
    reset       = 1'b1;
    pp_data     = 8'h00;
    pp_strobe_n = 1'b1;
    remote_ack  = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack_n", int'(pp_ack_n), 1);
    check("rst_busy", int'(pp_busy), 0);
    check("rst_d", int'(remote_d), 0);
    check("rst_rdy", int'(remote_data_ready), 0);
    check("rst_ovr", int'(overrun), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte with exact latency: first low sample at edge N, ready at N+7.
    model_byte(8'hA5);
    pp_data     = 8'hA5;
    pp_strobe_n = 1'b0;
    repeat (7) @(negedge clk);
    check("lat_rdy_n6", int'(remote_data_ready), 0);
    check("lat_ack_n6", int'(pp_ack_n), 1);
    @(negedge clk);
    check("lat_rdy_n7", int'(remote_data_ready), 1);
    check("lat_d_n7", int'(remote_d), 5);
    check("lat_ack_n7", int'(pp_ack_n), 0);
    t = 0;
    while (!pp_ack_n && t < 100) begin
      t++;
      if (t == 2) pp_strobe_n = 1'b1;
      @(negedge clk);
    end
    check("lat_ack_width", t, ACKW);
    repeat (4) @(negedge clk);
    check("single_busy", int'(pp_busy), 0);
    drain("single");

    // Glitch shorter than the filter.
    ack_seen    = 1'b0;
    pp_data     = 8'hFF;
    pp_strobe_n = 1'b0;
    repeat (3) @(negedge clk);
    pp_strobe_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!pp_ack_n) ack_seen = 1'b1;
    end
    check("glitch_ack", int'(ack_seen), 0);
    check("glitch_rdy", int'(remote_data_ready), 0);
    check("glitch_busy", int'(pp_busy), 0);

    // Fill, then overrun.
    send_byte(8'h10, 10);
    send_byte(8'h32, 10);
    send_byte(8'h54, 10);
    send_byte(8'h76, 10);
    check("full_busy", int'(pp_busy), 1);
    send_byte(8'h98, 10);
    check("drop_ovr", int'(overrun), 1);
    drain("fill");
    check("ovr_sticky", int'(overrun), 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    exp_ovr     = 1'b0;
    check("ovr_clr", int'(overrun), 0);

    // Pointer wrap over 40 nibbles.
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(i), 6);
      pop_one("wrap");
      pop_one("wrap");
    end
    check("wrap_ovr", int'(overrun), 0);
    @(negedge clk);
    check("wrap_rdy", int'(remote_data_ready), 0);

    // Six entries, then a pop lands on the PUSH cycle.
    send_byte(8'h21, 10);
    send_byte(8'h43, 10);
    send_byte(8'h65, 10);
    model_byte(8'hCB);
    pp_data     = 8'hCB;
    pp_strobe_n = 1'b0;
    repeat (7) @(negedge clk);
    pop_one("simul");
    check("simul_ack", int'(pp_ack_n), 0);
    repeat (30) @(negedge clk);
    pp_strobe_n = 1'b1;
    repeat (6) @(negedge clk);
    check("simul_ovr", int'(overrun), 0);
    check("simul_cnt", sb_q.size(), 7);
    drain("simul");

    // Held strobe pushes exactly one byte.
    send_byte(8'h5E, 100);
    drain("held");

    // Reset during ACK.
    send_byte(8'h77, 10);
    pp_data     = 8'h99;
    pp_strobe_n = 1'b0;
    t = 0;
    while (pp_ack_n && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("pre_rst_ack", int'(pp_ack_n), 0);
    repeat (3) @(negedge clk);
    reset       = 1'b1;
    pp_strobe_n = 1'b1;
    @(negedge clk);
    check("midrst_ack_n", int'(pp_ack_n), 1);
    check("midrst_rdy", int'(remote_data_ready), 0);
    reset = 1'b0;
    sb_q.delete();
    exp_ovr = 1'b0;
    @(negedge clk);

    // Pop while empty must not disturb the pointers.
    remote_ack = 1'b1;
    @(negedge clk);
    remote_ack = 1'b0;
    @(negedge clk);
    check("empty_pop_rdy", int'(remote_data_ready), 0);
    check("empty_pop_busy", int'(pp_busy), 0);
    send_byte(8'h3C, 10);
    drain("post_empty");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
